// File: rtl/dtack_generator.sv
// dtack_generator: 68k-style DTACK_L / BERR_L generation for the on-chip ROM, RAM
// and IO regions (fixed wait states) and for DRAM / CAN (external acknowledges).
// Optional bus-error timeout is enabled by defining the macro DTACK_TIMEOUT_EN.
module dtack_generator #(
    parameter int ROM_WAIT       = 0,
    parameter int RAM_WAIT       = 0,
    parameter int IO_WAIT        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic Clock,
    input  logic Reset_H,
    input  logic AS_L,
    input  logic UDS_L,
    input  logic LDS_L,
    input  logic OnChipRomSelect_H,
    input  logic OnChipRamSelect_H,
    input  logic DramSelect_H,
    input  logic IOSelect_H,
    input  logic CanBusSelect_H,
    input  logic DramDtack_L,
    input  logic CanBusDtack_L,
    output logic DTACK_L,
    output logic BERR_L
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, BERR} state_t;
    typedef enum logic [2:0] {RGN_NONE, RGN_ROM, RGN_RAM, RGN_IO, RGN_CAN, RGN_DRAM} region_t;

    // The timeout counter is 8 bits wide, so the limit must fit in 1..255.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
        $error("dtack_generator: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t     state;
    region_t    region;
    logic [7:0] waitCnt;

    region_t    selRegion;
    logic [7:0] selWait;
    logic       cycleStart;
    logic       ackNow;

    assign cycleStart = !AS_L && (!UDS_L || !LDS_L);

    // Priority-encode the region selects (ROM > RAM > IO > CAN > DRAM) and pick the wait count.
    always_comb begin
        selRegion = RGN_NONE;
        selWait   = 8'd0;
        if (OnChipRomSelect_H) begin
            selRegion = RGN_ROM;
            selWait   = 8'(ROM_WAIT);
        end else if (OnChipRamSelect_H) begin
            selRegion = RGN_RAM;
            selWait   = 8'(RAM_WAIT);
        end else if (IOSelect_H) begin
            selRegion = RGN_IO;
            selWait   = 8'(IO_WAIT);
        end else if (CanBusSelect_H) begin
            selRegion = RGN_CAN;
        end else if (DramSelect_H) begin
            selRegion = RGN_DRAM;
        end
    end

    // Acknowledge source for the latched region; no region means only a timeout can end WAIT.
    always_comb begin
        ackNow = 1'b0;
        case (region)
            RGN_ROM, RGN_RAM, RGN_IO: ackNow = (waitCnt == 8'd0);
            RGN_CAN:                  ackNow = !CanBusDtack_L;
            RGN_DRAM:                 ackNow = !DramDtack_L;
            default:                  ackNow = 1'b0;
        endcase
    end

`ifdef DTACK_TIMEOUT_EN
    logic [7:0] toCnt;

    // Bus-cycle FSM with registered DTACK_L / BERR_L and a WAIT timeout.
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            state   <= IDLE;
            region  <= RGN_NONE;
            waitCnt <= 8'd0;
            toCnt   <= 8'd0;
            DTACK_L <= 1'b1;
            BERR_L  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    DTACK_L <= 1'b1;
                    BERR_L  <= 1'b1;
                    if (cycleStart) begin
                        state   <= WAIT;
                        region  <= selRegion;
                        waitCnt <= selWait;
                        toCnt   <= 8'd0;
                    end
                end
                WAIT: begin
                    if (AS_L) begin
                        state <= IDLE;
                    end else if (ackNow) begin
                        // Acknowledge wins over a timeout landing on the same edge.
                        state   <= ACK;
                        DTACK_L <= 1'b0;
                    end else if (toCnt == 8'(TIMEOUT_CYCLES)) begin
                        state  <= BERR;
                        BERR_L <= 1'b0;
                    end else begin
                        toCnt <= toCnt + 8'd1;
                        if (waitCnt != 8'd0) waitCnt <= waitCnt - 8'd1;
                    end
                end
                ACK: begin
                    if (AS_L) begin
                        state   <= IDLE;
                        DTACK_L <= 1'b1;
                    end
                end
                BERR: begin
                    if (AS_L) begin
                        state  <= IDLE;
                        BERR_L <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    // Without the timeout there is no bus-error source at all.
    assign BERR_L = 1'b1;

    // Bus-cycle FSM with registered DTACK_L; WAIT ends only on acknowledge, AS_L high or reset.
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            state   <= IDLE;
            region  <= RGN_NONE;
            waitCnt <= 8'd0;
            DTACK_L <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    DTACK_L <= 1'b1;
                    if (cycleStart) begin
                        state   <= WAIT;
                        region  <= selRegion;
                        waitCnt <= selWait;
                    end
                end
                WAIT: begin
                    if (AS_L) begin
                        state <= IDLE;
                    end else if (ackNow) begin
                        state   <= ACK;
                        DTACK_L <= 1'b0;
                    end else if (waitCnt != 8'd0) begin
                        waitCnt <= waitCnt - 8'd1;
                    end
                end
                ACK: begin
                    if (AS_L) begin
                        state   <= IDLE;
                        DTACK_L <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_dtack_generator.sv
// Directed bench for dtack_generator: region priority, wait states, external
// acknowledges, abort, reset mid-cycle and (with DTACK_TIMEOUT_EN) bus-error timeout.
module tb_dtack_generator;

    logic Clock, Reset_H, AS_L, UDS_L, LDS_L;
    logic RomSel, RamSel, DramSel, IOSel, CanSel;
    logic DramDtack_L, CanBusDtack_L;
    logic DTACK_L, BERR_L;

    int checks = 0;
    int errors = 0;

    dtack_generator #(
        .ROM_WAIT(0), .RAM_WAIT(0), .IO_WAIT(2), .TIMEOUT_CYCLES(4)
    ) dut (
        .Clock(Clock), .Reset_H(Reset_H), .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L),
        .OnChipRomSelect_H(RomSel), .OnChipRamSelect_H(RamSel), .DramSelect_H(DramSel),
        .IOSelect_H(IOSel), .CanBusSelect_H(CanSel),
        .DramDtack_L(DramDtack_L), .CanBusDtack_L(CanBusDtack_L),
        .DTACK_L(DTACK_L), .BERR_L(BERR_L)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idleBus();
        AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
        RomSel = 1'b0; RamSel = 1'b0; DramSel = 1'b0; IOSel = 1'b0; CanSel = 1'b0;
        DramDtack_L = 1'b1; CanBusDtack_L = 1'b1;
    endtask

    initial begin
        idleBus();
        Reset_H = 1'b1;
        #1;
        tick(); tick();
        chk("reset_dtack", DTACK_L, 1'b1);
        chk("reset_berr", BERR_L, 1'b1);
        Reset_H = 1'b0;
        tick();

        // ROM read, zero wait: DTACK low at edge 1, held, released at the AS_L-high edge 4.
        RomSel = 1'b1; AS_L = 1'b0; UDS_L = 1'b0;
        tick();                                   // edge 0
        chk("rom_e0", DTACK_L, 1'b1);
        RomSel = 1'b0;
        tick(); chk("rom_e1", DTACK_L, 1'b0);
        chk("rom_e1_berr", BERR_L, 1'b1);
        tick(); chk("rom_e2", DTACK_L, 1'b0);
        tick(); chk("rom_e3", DTACK_L, 1'b0);
        AS_L = 1'b1; UDS_L = 1'b1;
        tick(); chk("rom_e4_release", DTACK_L, 1'b1);
        tick();

        // IO write, IO_WAIT=2: high at edges 1-2, low at edge 3.
        IOSel = 1'b1; AS_L = 1'b0; LDS_L = 1'b0;
        tick();
        IOSel = 1'b0;
        tick(); chk("io_e1", DTACK_L, 1'b1);
        tick(); chk("io_e2", DTACK_L, 1'b1);
        tick(); chk("io_e3", DTACK_L, 1'b0);
        idleBus();
        tick(); chk("io_release", DTACK_L, 1'b1);

        // Back-to-back: RAM beats DRAM (DramDtack_L held high) -> ack at edge 1.
        RamSel = 1'b1; DramSel = 1'b1; AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0;
        tick();
        tick(); chk("ram_over_dram_e1", DTACK_L, 1'b0);
        idleBus();
        tick(); chk("ram_release", DTACK_L, 1'b1);

        // DRAM: acknowledge appears before edge 6; select dropped after start is ignored.
        DramSel = 1'b1; AS_L = 1'b0; UDS_L = 1'b0;
        tick();                                   // edge 0
        DramSel = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick(); chk($sformatf("dram_wait_e%0d", e), DTACK_L, 1'b1);
        end
        DramDtack_L = 1'b0;
        tick(); chk("dram_e6", DTACK_L, 1'b0);
        idleBus();
        tick(); chk("dram_release", DTACK_L, 1'b1);

        // CAN with its acknowledge already low, DRAM ack high -> ack at edge 1.
        CanSel = 1'b1; CanBusDtack_L = 1'b0; AS_L = 1'b0; UDS_L = 1'b0;
        tick();
        tick(); chk("can_e1", DTACK_L, 1'b0);
        idleBus();
        tick(); chk("can_release", DTACK_L, 1'b1);

        // Aborted IO cycle: AS_L high at edge 2 -> IDLE, no DTACK at edge 3.
        IOSel = 1'b1; AS_L = 1'b0; UDS_L = 1'b0;
        tick();
        tick(); chk("abort_e1", DTACK_L, 1'b1);
        idleBus();
        tick(); chk("abort_e2", DTACK_L, 1'b1);
        tick(); chk("abort_e3", DTACK_L, 1'b1);
        chk("abort_berr", BERR_L, 1'b1);

        // Reset at edge 2 of an IO cycle, then a clean IO cycle.
        IOSel = 1'b1; AS_L = 1'b0; UDS_L = 1'b0;
        tick();
        tick(); chk("rst_mid_e1", DTACK_L, 1'b1);
        Reset_H = 1'b1;
        tick(); chk("rst_mid_e2", DTACK_L, 1'b1);
        Reset_H = 1'b0; idleBus();
        tick(); chk("rst_mid_e3", DTACK_L, 1'b1);
        tick(); chk("rst_mid_e4", DTACK_L, 1'b1);
        IOSel = 1'b1; AS_L = 1'b0; UDS_L = 1'b0;
        tick();
        IOSel = 1'b0;
        tick(); chk("post_rst_e1", DTACK_L, 1'b1);
        tick(); chk("post_rst_e2", DTACK_L, 1'b1);
        tick(); chk("post_rst_e3", DTACK_L, 1'b0);
        idleBus();
        tick(); chk("post_rst_release", DTACK_L, 1'b1);

`ifdef DTACK_TIMEOUT_EN
        // No select, TIMEOUT_CYCLES=4: BERR_L low at edge 5, DTACK_L never low.
        AS_L = 1'b0; UDS_L = 1'b0;
        tick();
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk($sformatf("to_berr_e%0d", e), BERR_L, 1'b1);
            chk($sformatf("to_dtack_e%0d", e), DTACK_L, 1'b1);
        end
        tick(); chk("to_berr_e5", BERR_L, 1'b0);
        chk("to_dtack_e5", DTACK_L, 1'b1);
        tick(); chk("to_berr_hold", BERR_L, 1'b0);
        idleBus();
        tick(); chk("to_berr_release", BERR_L, 1'b1);

        // DRAM ack lands on the timeout edge: acknowledge wins.
        DramSel = 1'b1; AS_L = 1'b0; UDS_L = 1'b0;
        tick();
        DramSel = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        DramDtack_L = 1'b0;
        tick(); chk("ack_vs_to_dtack", DTACK_L, 1'b0);
        chk("ack_vs_to_berr", BERR_L, 1'b1);
        idleBus();
        tick(); chk("ack_vs_to_release", DTACK_L, 1'b1);
`else
        // No timeout: an unselected cycle waits forever with neither output asserted.
        AS_L = 1'b0; UDS_L = 1'b0;
        tick();
        for (int e = 1; e <= 300; e++) begin
            tick();
            chk($sformatf("noto_berr_e%0d", e), BERR_L, 1'b1);
            chk($sformatf("noto_dtack_e%0d", e), DTACK_L, 1'b1);
        end
        idleBus();
        tick(); chk("noto_release", DTACK_L, 1'b1);
        // The FSM must be back in IDLE: a ROM cycle acknowledges at edge 1.
        RomSel = 1'b1; AS_L = 1'b0; UDS_L = 1'b0;
        tick();
        tick(); chk("noto_next_rom", DTACK_L, 1'b0);
        idleBus();
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
